// File: rtl/issue_queue_pkg.sv
// Shared definitions for the issue queue: renamed-op width, default field
// positions inside an op, and the wakeup tag-match helper.
`ifndef RENAMED_OP_SZ
`define RENAMED_OP_SZ 40
`endif

package issue_queue_pkg;

    localparam int IQ_READY_LSB     = 4;
    localparam int IQ_TAG_LSB       = 8;
    localparam int IQ_TAG_WIDTH     = 6;
    localparam int IQ_TAG_WIDTH_MAX = 16;

    // Callers zero-extend narrower tags to IQ_TAG_WIDTH_MAX, keeping the match exact.
    function automatic logic tag_match(input logic                        wv,
                                       input logic [IQ_TAG_WIDTH_MAX-1:0] wt,
                                       input logic [IQ_TAG_WIDTH_MAX-1:0] t);
        return wv && (wt == t);
    endfunction

endpackage

// File: rtl/issue_wakeup.sv
// Combinational wakeup for one op: sets the ready bit of every source whose
// tag matches a valid broadcast. All other op bits pass through unchanged.
module issue_wakeup
    import issue_queue_pkg::*;
#(
    parameter int INST_WIDTH = `RENAMED_OP_SZ,
    parameter int NUM_SRC    = 4,
    parameter int READY_LSB  = IQ_READY_LSB,
    parameter int TAG_LSB    = IQ_TAG_LSB,
    parameter int TAG_WIDTH  = IQ_TAG_WIDTH,
    parameter int NUM_WAKE   = 2
) (
    input  logic [INST_WIDTH-1:0]         op_in,
    input  logic [NUM_WAKE-1:0]           wake_valid,
    input  logic [NUM_WAKE*TAG_WIDTH-1:0] wake_tag,
    output logic [INST_WIDTH-1:0]         op_out
);

    always_comb begin
        op_out = op_in;
        for (int i = 0; i < NUM_SRC; i++) begin
            for (int k = 0; k < NUM_WAKE; k++) begin
                if (tag_match(wake_valid[k],
                              IQ_TAG_WIDTH_MAX'(wake_tag[k*TAG_WIDTH +: TAG_WIDTH]),
                              IQ_TAG_WIDTH_MAX'(op_in[TAG_LSB+i*TAG_WIDTH +: TAG_WIDTH]))) begin
                    op_out[READY_LSB+i] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/issue_queue.sv
// Collapsing issue queue: slot 0 is oldest, issues the oldest fully-ready op.
// Optional flush port enabled by defining ISSUE_QUEUE_FLUSH_EN.
module issue_queue
    import issue_queue_pkg::*;
#(
    parameter int INST_WIDTH = `RENAMED_OP_SZ,
    parameter int DEPTH      = 8,
    parameter int NUM_SRC    = 4,
    parameter int READY_LSB  = IQ_READY_LSB,
    parameter int TAG_LSB    = IQ_TAG_LSB,
    parameter int TAG_WIDTH  = IQ_TAG_WIDTH,
    parameter int NUM_WAKE   = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          entry_valid,
    input  logic [INST_WIDTH-1:0]         instr,
    output logic                          entry_ready,
    input  logic [NUM_WAKE-1:0]           wake_valid,
    input  logic [NUM_WAKE*TAG_WIDTH-1:0] wake_tag,
    input  logic                          next_ready,
    output logic                          result_valid,
    output logic [INST_WIDTH-1:0]         result_instr,
`ifdef ISSUE_QUEUE_FLUSH_EN
    input  logic                          flush,
`endif
    output logic [$clog2(DEPTH+1)-1:0]    count
);

    localparam int CW = $clog2(DEPTH+1);
    localparam int IW = $clog2(DEPTH);

    logic [INST_WIDTH-1:0] slot_q [DEPTH];
    logic [INST_WIDTH-1:0] slot_d [DEPTH];
    logic [INST_WIDTH-1:0] woken  [DEPTH];
    logic [INST_WIDTH-1:0] in_woken;
    logic [CW-1:0]         count_q, count_d, tail;
    logic [DEPTH-1:0]      issuable;
    logic [IW-1:0]         sel;
    logic                  any_issuable, issue_fire, enq_fire, flush_w;

`ifdef ISSUE_QUEUE_FLUSH_EN
    assign flush_w = flush;
`else
    assign flush_w = 1'b0;
`endif

    for (genvar g = 0; g <= DEPTH; g++) begin : g_wake
        if (g < DEPTH) begin : g_slot
            issue_wakeup #(
                .INST_WIDTH(INST_WIDTH), .NUM_SRC(NUM_SRC), .READY_LSB(READY_LSB),
                .TAG_LSB(TAG_LSB), .TAG_WIDTH(TAG_WIDTH), .NUM_WAKE(NUM_WAKE)
            ) u_wake (
                .op_in(slot_q[g]), .wake_valid(wake_valid), .wake_tag(wake_tag),
                .op_out(woken[g])
            );
        end else begin : g_in
            issue_wakeup #(
                .INST_WIDTH(INST_WIDTH), .NUM_SRC(NUM_SRC), .READY_LSB(READY_LSB),
                .TAG_LSB(TAG_LSB), .TAG_WIDTH(TAG_WIDTH), .NUM_WAKE(NUM_WAKE)
            ) u_wake (
                .op_in(instr), .wake_valid(wake_valid), .wake_tag(wake_tag),
                .op_out(in_woken)
            );
        end
    end

    // Selection looks at stored ready bits only; a wakeup becomes visible next cycle.
    always_comb begin
        sel          = '0;
        any_issuable = 1'b0;
        for (int i = DEPTH-1; i >= 0; i--) begin
            issuable[i] = (CW'(i) < count_q) && (&slot_q[i][READY_LSB +: NUM_SRC]);
            if (issuable[i]) begin
                sel          = IW'(i);
                any_issuable = 1'b1;
            end
        end
    end

    assign entry_ready  = (count_q < CW'(DEPTH));
    assign result_valid = any_issuable && !flush_w;
    assign result_instr = result_valid ? slot_q[sel] : '0;
    assign issue_fire   = result_valid && next_ready;
    assign enq_fire     = entry_valid && entry_ready;
    assign tail         = count_q - CW'(issue_fire);
    assign count        = count_q;

    always_comb begin
        for (int i = 0; i < DEPTH-1; i++) begin
            slot_d[i] = (issue_fire && (i >= int'(sel))) ? woken[i+1] : woken[i];
        end
        slot_d[DEPTH-1] = (issue_fire && (int'(sel) <= DEPTH-1)) ? '0 : woken[DEPTH-1];
        for (int i = 0; i < DEPTH; i++) begin
            if (enq_fire && (CW'(i) == tail)) slot_d[i] = in_woken;
            if (flush_w) slot_d[i] = '0;
        end
        count_d = flush_w ? '0 : count_q + CW'(enq_fire) - CW'(issue_fire);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) slot_q[i] <= '0;
        end else begin
            count_q <= count_d;
            for (int i = 0; i < DEPTH; i++) slot_q[i] <= slot_d[i];
        end
    end

endmodule

// File: tb/tb_issue_queue.sv
// Directed self-checking bench for issue_queue; flush checks run only when
// ISSUE_QUEUE_FLUSH_EN is defined.
module tb_issue_queue;

    localparam int IW = 40;

    logic          clk = 1'b0;
    logic          rst;
    logic          entry_valid;
    logic [IW-1:0] instr;
    logic          entry_ready;
    logic [1:0]    wake_valid;
    logic [11:0]   wake_tag;
    logic          next_ready;
    logic          result_valid;
    logic [IW-1:0] result_instr;
    logic [3:0]    count;
`ifdef ISSUE_QUEUE_FLUSH_EN
    logic          flush;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    issue_queue dut (
        .clk(clk), .rst(rst), .entry_valid(entry_valid), .instr(instr),
        .entry_ready(entry_ready), .wake_valid(wake_valid), .wake_tag(wake_tag),
        .next_ready(next_ready), .result_valid(result_valid),
        .result_instr(result_instr),
`ifdef ISSUE_QUEUE_FLUSH_EN
        .flush(flush),
`endif
        .count(count)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // id in [39:32], ready in [7:4], src i tag at [8+6i +: 6]
    function automatic logic [IW-1:0] mk(input logic [7:0] id, input logic [3:0] rdy,
                                         input logic [5:0] t0, input logic [5:0] t1,
                                         input logic [5:0] t2, input logic [5:0] t3);
        return {id, t3, t2, t1, t0, rdy, id[3:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    logic [IW-1:0] op_a, op_b, exp_op;
    logic [7:0]    drain_ids [7];
    logic [5:0]    drain_tags [7];

    initial begin
        rst = 1'b1; entry_valid = 1'b0; instr = '0; wake_valid = '0; wake_tag = '0;
        next_ready = 1'b0;
`ifdef ISSUE_QUEUE_FLUSH_EN
        flush = 1'b0;
`endif
        do_reset();
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_entry_ready", 64'(entry_ready), 64'd1);
        chk("rst_result_valid", 64'(result_valid), 64'd0);
        chk("rst_result_instr", 64'(result_instr), 64'd0);

        // single ready op: issues one cycle after enqueue
        op_a = mk(8'h11, 4'b1111, 6'd1, 6'd2, 6'd3, 6'd4);
        entry_valid = 1'b1; instr = op_a; next_ready = 1'b1;
        chk("empty_no_issue", 64'(result_valid), 64'd0);
        tick();
        entry_valid = 1'b0;
        chk("single_valid", 64'(result_valid), 64'd1);
        chk("single_instr", 64'(result_instr), 64'(op_a));
        chk("single_count1", 64'(count), 64'd1);
        tick();
        chk("single_count0", 64'(count), 64'd0);
        chk("single_drained", 64'(result_valid), 64'd0);

        // out of order: B overtakes A until tag 5 wakes A's src3
        op_a = mk(8'h2A, 4'b0111, 6'd1, 6'd2, 6'd3, 6'd5);
        op_b = mk(8'h2B, 4'b1111, 6'd1, 6'd2, 6'd3, 6'd4);
        next_ready = 1'b0; entry_valid = 1'b1; instr = op_a;
        tick();
        chk("ooo_a_not_ready", 64'(result_valid), 64'd0);
        instr = op_b;
        tick();
        entry_valid = 1'b0;
        chk("ooo_count2", 64'(count), 64'd2);
        chk("ooo_b_first", 64'(result_instr), 64'(op_b));
        next_ready = 1'b1;
        tick();
        chk("ooo_count1", 64'(count), 64'd1);
        chk("ooo_a_waiting", 64'(result_valid), 64'd0);
        wake_valid = 2'b01; wake_tag = {6'd0, 6'd5};
        chk("ooo_wake_not_same_cycle", 64'(result_valid), 64'd0);
        tick();
        wake_valid = '0;
        chk("ooo_a_valid", 64'(result_valid), 64'd1);
        chk("ooo_a_instr", 64'(result_instr), 64'(mk(8'h2A, 4'b1111, 6'd1, 6'd2, 6'd3, 6'd5)));
        tick();
        chk("ooo_count0", 64'(count), 64'd0);

        // incoming op woken by port 1 in the enqueue cycle
        op_a = mk(8'h33, 4'b1110, 6'd3, 6'd7, 6'd8, 6'd9);
        entry_valid = 1'b1; instr = op_a; next_ready = 1'b0;
        wake_valid = 2'b10; wake_tag = {6'd3, 6'd0};
        tick();
        entry_valid = 1'b0; wake_valid = '0;
        chk("inwake_valid", 64'(result_valid), 64'd1);
        chk("inwake_instr", 64'(result_instr), 64'(mk(8'h33, 4'b1111, 6'd3, 6'd7, 6'd8, 6'd9)));
        next_ready = 1'b1;
        tick();
        // near-miss tag (one bit off) must not wake
        op_a = mk(8'h34, 4'b1110, 6'd4, 6'd7, 6'd8, 6'd9);
        entry_valid = 1'b1; instr = op_a; next_ready = 1'b0;
        wake_valid = 2'b11; wake_tag = {6'd36, 6'd5};
        tick();
        entry_valid = 1'b0; wake_valid = '0;
        chk("exact_tag_nowake", 64'(result_valid), 64'd0);
        chk("exact_tag_count", 64'(count), 64'd1);
        do_reset();

        // fill to DEPTH with unready ops, op n waits on tag 10+n
        next_ready = 1'b0;
        for (int n = 0; n < 8; n++) begin
            entry_valid = 1'b1;
            instr = mk(8'(8'h40 + n), 4'b0000, 6'(10+n), 6'(10+n), 6'(10+n), 6'(10+n));
            tick();
        end
        chk("full_count", 64'(count), 64'd8);
        chk("full_entry_ready", 64'(entry_ready), 64'd0);
        chk("full_none_ready", 64'(result_valid), 64'd0);
        instr = mk(8'h4F, 4'b1111, 6'd0, 6'd0, 6'd0, 6'd0);
        tick();
        entry_valid = 1'b0;
        chk("full_reject_count", 64'(count), 64'd8);

        // wake slot 2, issue it while full: no bypass, so count drops to 7
        wake_valid = 2'b01; wake_tag = {6'd0, 6'd12};
        tick();
        wake_valid = '0;
        chk("mid_issue_instr", 64'(result_instr), 64'(mk(8'h42, 4'b1111, 6'd12, 6'd12, 6'd12, 6'd12)));
        next_ready = 1'b1; entry_valid = 1'b1;
        instr = mk(8'h5F, 4'b1111, 6'd0, 6'd0, 6'd0, 6'd0);
        chk("full_issue_no_bypass", 64'(entry_ready), 64'd0);
        tick();
        entry_valid = 1'b0; next_ready = 1'b0;
        chk("full_issue_count", 64'(count), 64'd7);

        // slot 2 now holds op 3: issue it with a same-cycle enqueue
        wake_valid = 2'b01; wake_tag = {6'd0, 6'd13};
        tick();
        wake_valid = '0;
        chk("mid2_instr", 64'(result_instr), 64'(mk(8'h43, 4'b1111, 6'd13, 6'd13, 6'd13, 6'd13)));
        next_ready = 1'b1; entry_valid = 1'b1;
        instr = mk(8'h60, 4'b0000, 6'd50, 6'd50, 6'd50, 6'd50);
        chk("mid2_entry_ready", 64'(entry_ready), 64'd1);
        tick();
        entry_valid = 1'b0; next_ready = 1'b0;
        chk("enq_issue_count", 64'(count), 64'd7);

        wake_valid = 2'b11;
        wake_tag = {6'd11, 6'd10}; tick();
        wake_tag = {6'd15, 6'd14}; tick();
        wake_tag = {6'd17, 6'd16}; tick();
        wake_tag = {6'd50, 6'd50}; tick();
        wake_valid = '0;
        drain_ids  = '{8'h40, 8'h41, 8'h44, 8'h45, 8'h46, 8'h47, 8'h60};
        drain_tags = '{6'd10, 6'd11, 6'd14, 6'd15, 6'd16, 6'd17, 6'd50};
        next_ready = 1'b1;
        for (int n = 0; n < 7; n++) begin
            exp_op = mk(drain_ids[n], 4'b1111, drain_tags[n], drain_tags[n],
                        drain_tags[n], drain_tags[n]);
            chk($sformatf("drain_%0d", n), 64'(result_instr), 64'(exp_op));
            tick();
        end
        chk("drain_count0", 64'(count), 64'd0);
        chk("drain_empty_instr", 64'(result_instr), 64'd0);

`ifdef ISSUE_QUEUE_FLUSH_EN
        do_reset();
        next_ready = 1'b0;
        for (int n = 0; n < 5; n++) begin
            entry_valid = 1'b1;
            instr = mk(8'(8'h70 + n), 4'b1111, 6'd1, 6'd1, 6'd1, 6'd1);
            tick();
        end
        chk("flush_pre_count", 64'(count), 64'd5);
        flush = 1'b1; next_ready = 1'b1;
        instr = mk(8'h7F, 4'b1111, 6'd1, 6'd1, 6'd1, 6'd1);
        chk("flush_rv_forced0", 64'(result_valid), 64'd0);
        tick();
        flush = 1'b0; entry_valid = 1'b0;
        chk("flush_count0", 64'(count), 64'd0);
        chk("flush_rv0", 64'(result_valid), 64'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
